// File: rtl/reg_file_ctx_if.sv
// rtl/reg_file_ctx_if.sv - Register-file bus: read/write ports plus context-switch and bank-clear handshakes
interface reg_file_ctx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CTX    = 4
);
    localparam int CTX_W = $clog2(NUM_CTX);

    logic [DATA_WIDTH-1:0] IN;
    logic [ADDR_WIDTH-1:0] INADDRESS;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic [DATA_WIDTH-1:0] OUT1;
    logic [DATA_WIDTH-1:0] OUT2;
    logic                  SW_REQ;
    logic [CTX_W-1:0]      SW_CTX;
    logic                  SW_ACK;
    logic                  CLR_REQ;
    logic [CTX_W-1:0]      CLR_CTX;
    logic                  CLR_DONE;
    logic                  BUSY;
    logic [CTX_W-1:0]      ACTIVE_CTX;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        output SW_REQ, SW_CTX, CLR_REQ, CLR_CTX,
        input  OUT1, OUT2, SW_ACK, CLR_DONE, BUSY, ACTIVE_CTX
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        input  SW_REQ, SW_CTX, CLR_REQ, CLR_CTX,
        output OUT1, OUT2, SW_ACK, CLR_DONE, BUSY, ACTIVE_CTX
    );
endinterface

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - Multi-context register file, single-cycle switch, hardware bank clear (option macro: REG_FILE_CTX_BYPASS_EN)
module reg_file_ctx #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CTX    = 4
) (
    input logic           CLK,
    input logic           RESET,
    reg_file_ctx_if.slave bus
);
    localparam int CTX_W = $clog2(NUM_CTX);
    localparam int NREG  = 1 << ADDR_WIDTH;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [NUM_CTX][NREG];

    logic [0:0]            state_q, state_d;
    logic [CTX_W-1:0]      active_q, active_d;
    logic [CTX_W-1:0]      clr_ctx_q, clr_ctx_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  sw_ack_q, sw_ack_d;
    logic                  clr_done_q, clr_done_d;

    logic                  wr_acc;
    logic                  fwd1, fwd2;
    logic [DATA_WIDTH-1:0] out1, out2;

    // A write lands only when the clear engine is not using the write path
    assign wr_acc = bus.WRITE && (state_q == S_IDLE) && (bus.INADDRESS != ZERO_IDX);

    // Control FSM next state: clear has priority over switch; the ack gate stops a held request re-firing
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        clr_ctx_d  = clr_ctx_q;
        cnt_d      = cnt_q;
        sw_ack_d   = 1'b0;
        clr_done_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.CLR_REQ) begin
                clr_ctx_d = bus.CLR_CTX;
                cnt_d     = ONE_IDX;
                state_d   = S_CLEAR;
            end else if (bus.SW_REQ && !sw_ack_q) begin
                active_d = bus.SW_CTX;
                sw_ack_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + ONE_IDX;
            if (cnt_q == LAST_IDX) begin
                state_d    = S_IDLE;
                clr_done_d = 1'b1;
            end
        end
    end

    // Control registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            active_q   <= '0;
            clr_ctx_q  <= '0;
            cnt_q      <= '0;
            sw_ack_q   <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            clr_ctx_q  <= clr_ctx_d;
            cnt_q      <= cnt_d;
            sw_ack_q   <= sw_ack_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Bank storage: normal writes go to the pre-edge active bank, clear zeroes one index per cycle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                for (int r = 0; r < NREG; r++) begin
                    mem_q[c][r] <= '0;
                end
            end
        end else if (state_q == S_CLEAR) begin
            mem_q[clr_ctx_q][cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[active_q][bus.INADDRESS] <= bus.IN;
        end
    end

    // Combinational read ports; x0 is hard-wired to zero
    always_comb begin
`ifdef REG_FILE_CTX_BYPASS_EN
        fwd1 = wr_acc && (bus.OUT1ADDRESS == bus.INADDRESS);
        fwd2 = wr_acc && (bus.OUT2ADDRESS == bus.INADDRESS);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        out1 = (bus.OUT1ADDRESS == ZERO_IDX) ? '0 : mem_q[active_q][bus.OUT1ADDRESS];
        out2 = (bus.OUT2ADDRESS == ZERO_IDX) ? '0 : mem_q[active_q][bus.OUT2ADDRESS];
        if (fwd1) begin
            out1 = bus.IN;
        end
        if (fwd2) begin
            out2 = bus.IN;
        end
    end

    assign bus.OUT1       = out1;
    assign bus.OUT2       = out2;
    assign bus.SW_ACK     = sw_ack_q;
    assign bus.CLR_DONE   = clr_done_q;
    assign bus.BUSY       = (state_q == S_CLEAR);
    assign bus.ACTIVE_CTX = active_q;
endmodule

// File: tb/tb_reg_file_ctx.sv
// tb/tb_reg_file_ctx.sv - Self-checking bench for reg_file_ctx
module tb_reg_file_ctx;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NC = 4;
    localparam int CW = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    reg_file_ctx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CTX(NC)) bus ();

    reg_file_ctx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CTX(NC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    typedef struct {
        int            tag;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    vec_t vecs[9];
    exp_t sb_q[$];
    exp_t sb_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: pop the expectation pushed for this cycle and compare the pre-edge read data
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check($sformatf("vec%0d.out1", sb_e.tag), bus.OUT1, sb_e.e1);
            check($sformatf("vec%0d.out2", sb_e.tag), bus.OUT2, sb_e.e2);
        end
    end

    task automatic rd_chk(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        @(negedge CLK);
        bus.OUT1ADDRESS = a1;
        bus.OUT2ADDRESS = a2;
        #1;
        check($sformatf("%s.out1[%0d]", name, a1), bus.OUT1, e1);
        check($sformatf("%s.out2[%0d]", name, a2), bus.OUT2, e2);
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            rd_chk(name, AW'(i), AW'(31 - i), 32'h0, 32'h0);
        end
    endtask

    task automatic do_switch(input logic [CW-1:0] ctx);
        int lat;
        lat = 0;
        @(negedge CLK);
        bus.SW_REQ = 1'b1;
        bus.SW_CTX = ctx;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge CLK);
            if (bus.SW_ACK) begin
                lat = n;
                bus.SW_REQ = 1'b0;
            end
        end
        bus.SW_REQ = 1'b0;
        check("sw_ack_latency", lat, 1);
        check("sw_active_ctx", 32'(bus.ACTIVE_CTX), 32'(ctx));
        @(negedge CLK);
        check("sw_ack_pulse", 32'(bus.SW_ACK), 32'h0);
    endtask

    task automatic run_clear(input logic [CW-1:0] ctx, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        @(negedge CLK);
        bus.CLR_REQ = 1'b1;
        bus.CLR_CTX = ctx;
        for (int g = 0; g < 60 && done_n == 0; g++) begin
            @(negedge CLK);
            if (bus.BUSY) busy_n++;
            if (bus.BUSY && busy_n == 5) begin
                bus.WRITE     = 1'b1;
                bus.INADDRESS = 5'd3;
                bus.IN        = 32'h77;
            end else begin
                bus.WRITE = 1'b0;
            end
            if (bus.CLR_DONE) begin
                done_n++;
                bus.CLR_REQ = 1'b0;
                check("clr_done_busy_low", 32'(bus.BUSY), 32'h0);
            end
        end
        bus.CLR_REQ = 1'b0;
        bus.WRITE   = 1'b0;
        @(negedge CLK);
        if (bus.CLR_DONE) done_n++;
        check("clr_idle_after", 32'(bus.BUSY), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_n, done_cyc, ack_cyc;

        vecs[0] = '{1'b1, 5'd1,  32'h0000_0003, 5'd2,  5'd3,  32'h0,          32'h0};
        vecs[1] = '{1'b1, 5'd2,  32'hDEAD_BEEF, 5'd1,  5'd0,  32'h3,          32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd1,  32'h0,          32'h3};
        vecs[3] = '{1'b1, 5'd31, 32'h1234_5678, 5'd2,  5'd0,  32'hDEAD_BEEF,  32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'h1234_5678,  32'h3};
        vecs[5] = '{1'b0, 5'd1,  32'h55,        5'd1,  5'd31, 32'h3,          32'h1234_5678};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h3,          32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 5'd16, 32'hA5A5_A5A5, 5'd15, 5'd0,  32'h0,          32'h0};
        vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd16, 5'd31, 32'hA5A5_A5A5,  32'h1234_5678};

        bus.IN = '0; bus.INADDRESS = '0; bus.WRITE = 1'b0;
        bus.OUT1ADDRESS = '0; bus.OUT2ADDRESS = '0;
        bus.SW_REQ = 1'b0; bus.SW_CTX = '0; bus.CLR_REQ = 1'b0; bus.CLR_CTX = '0;

        // Reset for one edge
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rst_active_ctx", 32'(bus.ACTIVE_CTX), 32'h0);
        check("rst_busy", 32'(bus.BUSY), 32'h0);
        check("rst_sw_ack", 32'(bus.SW_ACK), 32'h0);
        check("rst_clr_done", 32'(bus.CLR_DONE), 32'h0);
        read_all_zero("rst_ctx0");
        do_switch(2'd3);
        read_all_zero("rst_ctx3");
        do_switch(2'd0);

        // Table-driven writes and reads in context 0
        for (int i = 0; i < 9; i++) begin
            @(posedge CLK);
            #1;
            bus.WRITE       = vecs[i].wr;
            bus.INADDRESS   = vecs[i].waddr;
            bus.IN          = vecs[i].wdata;
            bus.OUT1ADDRESS = vecs[i].ra1;
            bus.OUT2ADDRESS = vecs[i].ra2;
            sb_q.push_back('{i, vecs[i].e1, vecs[i].e2});
        end
        @(posedge CLK);
        #1;
        bus.WRITE = 1'b0;
        @(negedge CLK);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        // Banks are isolated across a switch
        do_switch(2'd2);
        rd_chk("ctx2_x1", 5'd1, 5'd31, 32'h0, 32'h0);
        do_switch(2'd0);
        rd_chk("ctx0_back", 5'd1, 5'd31, 32'h3, 32'h1234_5678);

        // Fill ctx 1, then clear it with a dropped write in the middle
        do_switch(2'd1);
        for (int i = 1; i < 32; i++) begin
            @(negedge CLK);
            bus.WRITE     = 1'b1;
            bus.INADDRESS = AW'(i);
            bus.IN        = 32'hA5A5_A5A5;
        end
        @(negedge CLK);
        bus.WRITE = 1'b0;
        rd_chk("ctx1_fill", 5'd7, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        run_clear(2'd1, busy_n, done_n);
        check("clr_busy_cycles", busy_n, 31);
        check("clr_done_pulses", done_n, 1);
        read_all_zero("ctx1_cleared");
        do_switch(2'd0);
        rd_chk("ctx0_kept_a", 5'd1, 5'd2, 32'h3, 32'hDEAD_BEEF);
        rd_chk("ctx0_kept_b", 5'd16, 5'd31, 32'hA5A5_A5A5, 32'h1234_5678);

        // Clear and switch requested together: clear first, ack one cycle after done
        done_cyc = -1;
        ack_cyc  = -1;
        @(negedge CLK);
        bus.CLR_REQ = 1'b1; bus.CLR_CTX = 2'd2;
        bus.SW_REQ  = 1'b1; bus.SW_CTX  = 2'd3;
        for (int c = 1; c <= 60 && ack_cyc < 0; c++) begin
            @(negedge CLK);
            if (bus.CLR_DONE) begin
                done_cyc = c;
                bus.CLR_REQ = 1'b0;
            end
            if (bus.SW_ACK) begin
                ack_cyc = c;
                bus.SW_REQ = 1'b0;
            end
        end
        bus.CLR_REQ = 1'b0;
        bus.SW_REQ  = 1'b0;
        check("simul_done_cycle", done_cyc, 32);
        check("simul_ack_cycle", ack_cyc, 33);
        check("simul_active_ctx", 32'(bus.ACTIVE_CTX), 32'h3);

        // Reset in the 10th clear cycle aborts the clear
        busy_n = 0;
        @(negedge CLK);
        bus.CLR_REQ = 1'b1;
        bus.CLR_CTX = 2'd0;
        for (int c = 0; c < 40 && busy_n < 10; c++) begin
            @(negedge CLK);
            if (bus.BUSY) busy_n++;
        end
        check("abort_reached_cycle10", busy_n, 10);
        RESET = 1'b0;
        bus.CLR_REQ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        check("abort_busy", 32'(bus.BUSY), 32'h0);
        check("abort_active_ctx", 32'(bus.ACTIVE_CTX), 32'h0);
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (bus.CLR_DONE) done_n++;
        end
        check("abort_no_done", done_n, 0);
        rd_chk("abort_wiped", 5'd31, 5'd1, 32'h0, 32'h0);

        // Same-cycle write visibility, and x0 never forwarded
        @(negedge CLK);
        bus.WRITE = 1'b1; bus.INADDRESS = 5'd5; bus.IN = 32'h1234;
        bus.OUT1ADDRESS = 5'd0; bus.OUT2ADDRESS = 5'd5;
        #1;
`ifdef REG_FILE_CTX_BYPASS_EN
        check("fwd_same_cycle", bus.OUT2, 32'h1234);
`else
        check("nofwd_same_cycle", bus.OUT2, 32'h0);
`endif
        @(negedge CLK);
        bus.WRITE = 1'b1; bus.INADDRESS = 5'd0; bus.IN = 32'hFFFF_FFFF;
        #1;
        check("x0_same_cycle", bus.OUT1, 32'h0);
        check("x5_after_edge", bus.OUT2, 32'h1234);
        @(negedge CLK);
        bus.WRITE = 1'b0;
        #1;
        check("x0_after_edge", bus.OUT1, 32'h0);

        // Write and switch in the same cycle: write lands in the old context
        @(negedge CLK);
        bus.WRITE = 1'b1; bus.INADDRESS = 5'd9; bus.IN = 32'h99;
        bus.SW_REQ = 1'b1; bus.SW_CTX = 2'd1;
        @(negedge CLK);
        bus.WRITE = 1'b0;
        check("wsw_ack", 32'(bus.SW_ACK), 32'h1);
        bus.SW_REQ = 1'b0;
        bus.OUT1ADDRESS = 5'd9;
        #1;
        check("wsw_new_ctx_x9", bus.OUT1, 32'h0);
        do_switch(2'd0);
        rd_chk("wsw_old_ctx", 5'd9, 5'd5, 32'h99, 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_ctx.md
Name: reg_file_ctx

Overview:
- Multi-context RISC-V integer register file. The generalised successor to the single-bank 32x32 reg_file.
- Holds NUM_CTX independent register banks, one per OS context. Two asynchronous read ports and one synchronous write port always address the active bank.
- Supports a single-cycle context switch and a multi-cycle hardware bank clear, so the OS context-switch path needs no software save/restore of registers.
- Sits in the ID/WB stages of the RiscV-Processor pipeline, in place of reg_file.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; 2^ADDR_WIDTH registers per bank.
- NUM_CTX, 4, number of context banks; must be a power of two, >= 2.
- CTX_W, $clog2(NUM_CTX), context-ID width (derived, not overridden).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset; sampled on posedge CLK.
- IN  in  DATA_WIDTH  write data.
- INADDRESS  in  ADDR_WIDTH  write register index.
- WRITE  in  1  write enable.
- OUT1ADDRESS  in  ADDR_WIDTH  read port 1 index.
- OUT2ADDRESS  in  ADDR_WIDTH  read port 2 index.
- OUT1  out  DATA_WIDTH  read port 1 data.
- OUT2  out  DATA_WIDTH  read port 2 data.
- SW_REQ  in  1  context-switch request, level; held until SW_ACK.
- SW_CTX  in  CTX_W  target context ID.
- SW_ACK  out  1  one-cycle pulse: switch done.
- CLR_REQ  in  1  bank-clear request, level; held until CLR_DONE.
- CLR_CTX  in  CTX_W  bank to clear.
- CLR_DONE  out  1  one-cycle pulse: clear done.
- BUSY  out  1  high while a clear is in progress.
- ACTIVE_CTX  out  CTX_W  current active context.

Behaviour:
- Reset (RESET==0 at posedge):
  - all registers of all banks = 0.
  - ACTIVE_CTX=0, SW_ACK=0, CLR_DONE=0, BUSY=0, FSM=IDLE, clear counter=0.
  - Reset mid-clear aborts the clear; no CLR_DONE is issued.
- Reads are combinational from bank ACTIVE_CTX:
  - index 0 always reads 0.
  - no read latency; OUT1 and OUT2 follow the address and data changes in the same cycle.
- Writes:
  - accepted at posedge when WRITE=1, FSM=IDLE and INADDRESS!=0.
  - target is bank ACTIVE_CTX as registered before that edge.
  - writes to index 0 are dropped.
  - WRITE while BUSY is dropped; upstream must stall on BUSY.
- FSM states: IDLE, CLEAR.
- IDLE transitions, in priority order:
  - CLR_REQ=1: latch clr_ctx=CLR_CTX, counter=1, go to CLEAR, BUSY=1 next cycle.
  - else SW_REQ=1 and !SW_ACK: ACTIVE_CTX<=SW_CTX and SW_ACK=1 for exactly one cycle.
    - Requester drops SW_REQ in the ACK cycle.
    - SW_REQ still high in the cycle after ACK is treated as a new request.
  - SW_CTX==ACTIVE_CTX is legal; it is acknowledged with no state change.
- CLEAR behaviour:
  - each cycle writes 0 to bank clr_ctx at index counter, then counter++.
  - on the cycle writing index 2^ADDR_WIDTH-1: next state IDLE, BUSY=0, CLR_DONE=1 for one cycle.
  - clear latency = 2^ADDR_WIDTH-1 cycles of BUSY (31 at default).
  - SW_REQ during CLEAR is held off; it is serviced in the first IDLE cycle.
  - reads stay live during CLEAR; if clr_ctx==ACTIVE_CTX, reads show partially cleared contents.
  - counter wraps in ADDR_WIDTH bits; the terminal-index compare ends the sequence, so no wrap occurs in practice.
- Simultaneous CLR_REQ and SW_REQ in IDLE: clear wins; the switch waits.
- Same-cycle WRITE and SW_REQ in IDLE: the write lands in the old context; the switch takes effect for the next cycle's reads.

Optional Feature:
- Macro: REG_FILE_CTX_BYPASS_EN.
- Defined: write-to-read forwarding. If WRITE=1, the write is accepted this cycle, and OUTnADDRESS==INADDRESS!=0, then OUTn=IN combinationally in that cycle.
- Undefined: OUTn shows the old stored value until after the edge.
- Forwarding is never applied to index 0 or while BUSY.

Test Plan:
- Reset low 1 cycle, then read all indices in ctx 0 and ctx 3 -> OUT1=OUT2=0, ACTIVE_CTX=0, BUSY=0.
- In ctx 0 write x1=0x00000003 -> OUT1(addr1)=3 next cycle. Switch to ctx 2 -> SW_ACK one pulse, OUT1(addr1)=0. Switch back to ctx 0 -> x1=3.
- Write x0=0xFFFFFFFF -> OUT1(addr0)=0.
- Fill ctx 1 x1..x31 with 0xA5A5A5A5, then CLR_REQ ctx 1:
  - BUSY high for exactly 31 cycles, then CLR_DONE pulse.
  - all ctx 1 regs read 0; ctx 0 unchanged.
  - a WRITE issued mid-clear is dropped.
- CLR_REQ and SW_REQ(ctx 3) asserted together -> CLEAR first; SW_ACK is issued the cycle after CLR_DONE; ACTIVE_CTX=3.
- Reset asserted at clear cycle 10 -> BUSY=0 and no CLR_DONE. With REG_FILE_CTX_BYPASS_EN: write x5=0x1234 with OUT2ADDRESS=5 -> OUT2=0x1234 in the same cycle.
